// File: rtl/mul_div_pkg.sv
// ============================================================================
// Module : mul_div_pkg
// Brief  : Shared types and constants for the multi-cycle multiply/divide unit
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mul_div_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mul_div_if.sv
// ============================================================================
// Module : mul_div_if
// Brief  : Start/busy/done handshake and operand/result bus of the mul/div unit
//          (op_signed present only when MULDIV_SIGNED_EN is defined)
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mul_div_if
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic             op;
`ifdef MULDIV_SIGNED_EN
    logic             op_signed;
`endif
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;

    modport master (
`ifdef MULDIV_SIGNED_EN
        output op_signed,
`endif
        output start, op, operand_a, operand_b,
        input  busy, done, result_lo, result_hi, div_by_zero
    );

    modport slave (
`ifdef MULDIV_SIGNED_EN
        input  op_signed,
`endif
        input  start, op, operand_a, operand_b,
        output busy, done, result_lo, result_hi, div_by_zero
    );

endinterface

`default_nettype wire

// File: rtl/mul_div_step.sv
// ============================================================================
// Module : mul_div_step
// Brief  : One combinational iteration: shift-add multiply or restoring divide
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mul_div_step
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_shreg,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_shreg
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    // Divide keeps the low WIDTH bits of the difference: when the trial
    // subtract succeeds the true difference is below the divisor.
    assign w_sum   = {1'b0, i_acc} + {1'b0, i_opnd};
    assign w_shift = {i_acc, i_shreg[WIDTH-1]};
    assign w_diff  = w_shift[WIDTH-1:0] - i_opnd;
    assign w_fits  = (w_shift >= {1'b0, i_opnd});

    always_comb begin
        o_acc   = i_acc;
        o_shreg = i_shreg;
        if (i_op == OP_MUL) begin
            if (i_shreg[0]) begin
                o_acc   = w_sum[WIDTH:1];
                o_shreg = {w_sum[0], i_shreg[WIDTH-1:1]};
            end else begin
                o_acc   = {1'b0, i_acc[WIDTH-1:1]};
                o_shreg = {i_acc[0], i_shreg[WIDTH-1:1]};
            end
        end else begin
            o_shreg = {i_shreg[WIDTH-2:0], w_fits};
            o_acc   = w_fits ? w_diff : w_shift[WIDTH-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module : mul_div_unit
// Brief  : Multi-cycle unsigned multiply/divide, one bit per clock.
//          Define MULDIV_SIGNED_EN to add two's-complement operation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic     Clk,
    input  logic     Reset_al,
    mul_div_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             op_q,        op_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic [WIDTH-1:0] opnd_q,      opnd_d;
    logic [WIDTH-1:0] dvd_q,       dvd_d;
    logic             zero_q,      zero_d;
    logic             neg_res_q,   neg_res_d;
    logic             neg_rem_q,   neg_rem_d;
    logic [WIDTH-1:0] res_lo_q,    res_lo_d;
    logic [WIDTH-1:0] res_hi_q,    res_hi_d;
    logic             dbz_q,       dbz_d;

    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_sh_nx;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

`ifdef MULDIV_SIGNED_EN
    assign w_sa = bus.op_signed & bus.operand_a[WIDTH-1];
    assign w_sb = bus.op_signed & bus.operand_b[WIDTH-1];
`else
    assign w_sa = 1'b0;
    assign w_sb = 1'b0;
`endif

    // The iteration always runs on magnitudes; signs are reapplied at the end.
    assign w_mag_a = w_sa ? -bus.operand_a : bus.operand_a;
    assign w_mag_b = w_sb ? -bus.operand_b : bus.operand_b;

    mul_div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .i_op    (op_q),
        .i_acc   (acc_q),
        .i_shreg (shreg_q),
        .i_opnd  (opnd_q),
        .o_acc   (w_acc_nx),
        .o_shreg (w_sh_nx)
    );

    assign w_prod_u = {w_acc_nx, w_sh_nx};
    assign w_prod   = neg_res_q ? -w_prod_u : w_prod_u;
    assign w_quo    = neg_res_q ? -w_sh_nx  : w_sh_nx;
    assign w_rem    = neg_rem_q ? -w_acc_nx : w_acc_nx;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        acc_d     = acc_q;
        shreg_d   = shreg_q;
        opnd_d    = opnd_q;
        dvd_d     = dvd_q;
        zero_d    = zero_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    count_d   = '0;
                    op_d      = bus.op;
                    acc_d     = '0;
                    dvd_d     = bus.operand_a;
                    zero_d    = (bus.operand_b == '0);
                    neg_res_d = w_sa ^ w_sb;
                    neg_rem_d = w_sa;
                    if (bus.op == OP_MUL) begin
                        shreg_d = w_mag_b;
                        opnd_d  = w_mag_a;
                    end else begin
                        shreg_d = w_mag_a;
                        opnd_d  = w_mag_b;
                    end
                end
            end

            RUN: begin
                acc_d   = w_acc_nx;
                shreg_d = w_sh_nx;
                count_d = count_q + C_ONE;
                // Last iteration: result registers load straight from the step output.
                if (count_q == C_LAST) begin
                    state_d = DONE;
                    if (op_q == OP_MUL) begin
                        res_lo_d = w_prod[WIDTH-1:0];
                        res_hi_d = w_prod[2*WIDTH-1:WIDTH];
                        dbz_d    = 1'b0;
                    end else if (zero_q) begin
                        res_lo_d = '1;
                        res_hi_d = dvd_q;
                        dbz_d    = 1'b1;
                    end else begin
                        res_lo_d = w_quo;
                        res_hi_d = w_rem;
                        dbz_d    = 1'b0;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_al) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= OP_MUL;
            acc_q     <= '0;
            shreg_q   <= '0;
            opnd_q    <= '0;
            dvd_q     <= '0;
            zero_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            shreg_q   <= shreg_d;
            opnd_q    <= opnd_d;
            dvd_q     <= dvd_d;
            zero_q    <= zero_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.result_lo   = res_lo_q;
    assign bus.result_hi   = res_hi_q;
    assign bus.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module : tb_mul_div_unit
// Brief  : Scoreboard bench for mul_div_unit (signed cases with MULDIV_SIGNED_EN)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;
    import mul_div_pkg::*;

    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dbz;
    } exp_t;

    logic Clk;
    logic Reset_al;
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   run_cnt;
    int   done_cnt;
    int   spurious;
    int   last_done_cyc;
    int   prev_done_cyc;
    bit   chk_next;
    exp_t exp_q[$];
    exp_t e;

    mul_div_if #(.WIDTH(WIDTH)) bus ();

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .Reset_al (Reset_al),
        .bus      (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [15:0] a, input logic [15:0] b,
                                   input logic s);
        exp_t r;
        int   sa, sb, q, rm;
        logic [31:0] p;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        r.dbz = 1'b0;
        if (o == OP_MUL) begin
            if (s) p = sa * sb;
            else   p = {16'h0, a} * {16'h0, b};
            r.lo = p[15:0];
            r.hi = p[31:16];
        end else if (b == 16'h0) begin
            r.lo  = 16'hFFFF;
            r.hi  = a;
            r.dbz = 1'b1;
        end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
            r.lo = 16'h8000;
            r.hi = 16'h0000;
        end else if (s) begin
            q  = sa / sb;
            rm = sa % sb;
            r.lo = q[15:0];
            r.hi = rm[15:0];
        end else begin
            r.lo = a / b;
            r.hi = a % b;
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard on every done pulse and checks latency.
    always @(negedge Clk) begin
        cyc++;
        if (bus.done) begin
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                spurious++;
            end else begin
                e = exp_q.pop_front();
                check_value("latency", run_cnt, WIDTH);
                check_value("result_lo", bus.result_lo, e.lo);
                check_value("result_hi", bus.result_hi, e.hi);
                check_value("div_by_zero", bus.div_by_zero, e.dbz);
            end
            run_cnt  = 0;
            chk_next = 1'b1;
        end else begin
            if (chk_next) begin
                check_value("busy_after_done", bus.busy, 0);
                chk_next = 1'b0;
            end
            if (bus.busy) run_cnt++;
            else          run_cnt = 0;
        end
    end

    task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b, input logic s);
        int guard;
        @(posedge Clk); #1;
        guard = 0;
        while (bus.busy && guard < 50) begin
            @(posedge Clk); #1;
            guard++;
        end
        bus.start     = 1'b1;
        bus.op        = o;
        bus.operand_a = a;
        bus.operand_b = b;
`ifdef MULDIV_SIGNED_EN
        bus.op_signed = s;
`endif
        exp_q.push_back(model(o, a, b, s));
        @(posedge Clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge Clk);
        if (exp_q.size() != 0) begin
            check_value("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        ro;
        int          d0;
        n_tests = 0; n_fail = 0; cyc = 0; run_cnt = 0; done_cnt = 0; spurious = 0;
        last_done_cyc = 0; prev_done_cyc = 0; chk_next = 1'b0;
        bus.start = 1'b0; bus.op = OP_MUL; bus.operand_a = '0; bus.operand_b = '0;
`ifdef MULDIV_SIGNED_EN
        bus.op_signed = 1'b0;
`endif
        Reset_al = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset_al = 1'b1;
        @(negedge Clk);
        check_value("rst_busy", bus.busy, 0);
        check_value("rst_done", bus.done, 0);
        check_value("rst_lo", bus.result_lo, 0);
        check_value("rst_hi", bus.result_hi, 0);
        check_value("rst_dbz", bus.div_by_zero, 0);

        issue(OP_MUL, 16'h0003, 16'h0005, 1'b0); wait_done();
        issue(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0); wait_done();
        issue(OP_DIV, 16'd100,  16'd7,    1'b0); wait_done();
        issue(OP_DIV, 16'h1234, 16'h0000, 1'b0); wait_done();
        issue(OP_MUL, 16'h0007, 16'h0009, 1'b0); wait_done();
        issue(OP_DIV, 16'h0005, 16'h0009, 1'b0); wait_done();

        // Start pulses and operand changes while running must be ignored.
        d0 = done_cnt;
        issue(OP_DIV, 16'd50, 16'd5, 1'b0);
        repeat (2) @(posedge Clk);
        #1 bus.start = 1'b1; bus.op = OP_MUL; bus.operand_a = 16'd9; bus.operand_b = 16'd9;
        @(posedge Clk); #1 bus.start = 1'b0;
        repeat (6) @(posedge Clk);
        #1 bus.start = 1'b1;
        @(posedge Clk); #1 bus.start = 1'b0;
        wait_done();
        repeat (24) @(negedge Clk);
        check_value("single_done", done_cnt - d0, 1);

        // Reset in the middle of RUN aborts with cleared outputs.
        issue(OP_MUL, 16'h00FF, 16'h0101, 1'b0);
        repeat (7) @(posedge Clk);
        #1 Reset_al = 1'b0;
        @(posedge Clk); #1 Reset_al = 1'b1;
        exp_q.delete();
        @(negedge Clk);
        check_value("abort_busy", bus.busy, 0);
        check_value("abort_done", bus.done, 0);
        check_value("abort_lo", bus.result_lo, 0);
        check_value("abort_hi", bus.result_hi, 0);
        issue(OP_MUL, 16'd2, 16'd3, 1'b0); wait_done();

        // Held start gives back-to-back operations every WIDTH+2 cycles.
        issue(OP_MUL, 16'h1234, 16'h0010, 1'b0);
        #0 bus.start = 1'b1;
        exp_q.push_back(model(OP_MUL, 16'h1234, 16'h0010, 1'b0));
        for (int i = 0; i < 40 && exp_q.size() > 1; i++) @(negedge Clk);
        @(posedge Clk); #1;
        @(posedge Clk); #1 bus.start = 1'b0;
        wait_done();
        check_value("b2b_gap", last_done_cyc - prev_done_cyc, WIDTH + 2);

        for (int i = 0; i < 8; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = (i == 3) ? 16'h0 : 16'($urandom_range(0, 16'hFFFF));
            issue(ro, ra, rb, 1'b0);
            wait_done();
        end

`ifdef MULDIV_SIGNED_EN
        issue(OP_DIV, 16'hFFF9, 16'h0002, 1'b1); wait_done();
        issue(OP_MUL, 16'hFFFD, 16'h0004, 1'b1); wait_done();
        issue(OP_DIV, 16'h8000, 16'hFFFF, 1'b1); wait_done();
        issue(OP_DIV, 16'hFFF0, 16'h0000, 1'b1); wait_done();
        issue(OP_MUL, 16'h8000, 16'h8000, 1'b1); wait_done();
`endif

        repeat (4) @(negedge Clk);
        check_value("spurious_done", spurious, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle integer multiply/divide execution unit, downstream of the register file. Consumes the two register read ports (SR1/SR2 outputs) as operands, sitting beside the single-cycle ALU. It iterates one bit per clock and produces a result pair that the control FSM gates onto the data bus for write-back. Start/busy/done handshake with the main control state machine.

Parameters:
WIDTH, 16, operand and result-half width in bits
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
Clk  input  1  system clock, all state on rising edge
Reset_al  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  1  0 = MUL, 1 = DIV
operand_a  input  WIDTH  multiplicand / dividend (from SR1 read port)
operand_b  input  WIDTH  multiplier / divisor (from SR2 read port)
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, results valid
result_lo  output  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient
result_hi  output  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
div_by_zero  output  1  set with DIV results when operand_b == 0; cleared for MUL

Behaviour:
- Reset (Reset_al low at edge): state IDLE; busy, done, div_by_zero = 0; result_lo/result_hi = 0; counter = 0. Reset mid-operation aborts immediately, with no partial result.
- States: IDLE -> RUN on start=1; RUN -> RUN while count < WIDTH-1; RUN -> DONE on the WIDTH-th iteration edge; DONE -> IDLE unconditionally after one cycle.
- On the accepting edge: operand_a, operand_b, op latched; count = 0. Operand inputs may change afterwards without effect.
- MUL: shift-add, one multiplier bit per RUN cycle; 2*WIDTH-bit unsigned product.
- DIV: restoring shift-subtract, one quotient bit per RUN cycle; unsigned.
- Latency: start accepted at edge k -> done = 1 and results valid in the cycle following edge k+WIDTH (16 cycles at default). Latency is fixed, including divide-by-zero.
- done is high for exactly one cycle (DONE state). result_lo/result_hi/div_by_zero hold their values until the next accepted start. Intermediate values are never visible on result ports.
- start while busy (RUN or DONE): ignored, with no queuing. start held high continuously: re-accepted on the first IDLE cycle, giving back-to-back ops every WIDTH+2 cycles.
- Divide by zero: result_lo = all ones, result_hi = dividend, div_by_zero = 1.
- op == DIV with operand_a < operand_b: quotient 0, remainder = operand_a.

Optional Feature:
MULDIV_SIGNED_EN. When defined: adds input op_signed (1 bit, latched with op). When op_signed = 1, operands are two's complement. Magnitudes are computed on accept, and the sign is corrected on the RUN->DONE edge, so latency is unchanged.
- MUL: full signed 2*WIDTH product.
- DIV: quotient truncates toward zero; remainder takes the dividend's sign.
- Overflow 0x8000/0xFFFF: quotient 0x8000, remainder 0.
- Divide by zero: same values as unsigned.
When not defined: the port is absent and all ops are unsigned.

Decomposition:
- Package mul_div_pkg holds: state enum (IDLE, RUN, DONE); op encoding constants OP_MUL = 1'b0, OP_DIV = 1'b1; default WIDTH.
- One sub-module, mul_div_step: a combinational single-iteration datapath taking the accumulator/remainder, shift register, divisor/multiplicand and op, and producing the next values. The top holds the FSM, counter and registers.

Test Plan:
- Reset, then MUL 0x0003 x 0x0005 -> after 16 cycles: done pulse, lo = 0x000F, hi = 0x0000, div_by_zero = 0; busy low the following cycle.
- MUL 0xFFFF x 0xFFFF -> lo = 0x0001, hi = 0xFFFE; DIV 100 / 7 -> lo = 0x000E, hi = 0x0002.
- DIV 0x1234 / 0 -> lo = 0xFFFF, hi = 0x1234, div_by_zero = 1 at the same 16-cycle latency. A following MUL clears the flag.
- start pulsed at cycles 3 and 10 after an accepted DIV 50/5 -> the pulses are ignored; a single done pulse with lo = 10, hi = 0. Operand change during RUN has no effect.
- Reset_al low at RUN cycle 8 -> next cycle busy = 0, done = 0, results 0. A fresh MUL 2 x 3 then yields 6.
- (MULDIV_SIGNED_EN) DIV -7/2 -> lo = 0xFFFD, hi = 0xFFFF; MUL -3 x 4 -> lo = 0xFFF4, hi = 0xFFFF; DIV 0x8000/0xFFFF -> lo = 0x8000, hi = 0.
